tour_cmd_seq: RTL and testbench
===============================

TOUR_CMD_SEQ -- requirements
Module: tour_cmd_seq

Interface
REQ-001 SHALL have parameter NUM_MOVES, default 24, number of knight moves in one tour (board squares minus 1); legal range 2..255.
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_MOVES), width of the move index.
REQ-003 SHALL have parameter HORIZ_FIRST, default 0: 0 = vertical leg then horizontal leg; 1 = horizontal leg then vertical leg.
REQ-004 SHALL have ports: clk  in  1  system clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: start_tour  in  1  one-cycle pulse, solved tour ready; move  in  8  one-hot knight move at mv_indx; mv_indx  out  IDX_W  move being executed.
REQ-006 SHALL have ports: cmd_UART  in  16  remote command; cmd_rdy_UART  in  1  remote command valid; clr_cmd_rdy  in  1  command consumed, from the command processor; clr_cmd_rdy_UART  out  1  clear to the UART wrapper.
REQ-007 SHALL have ports: send_resp  in  1  one-cycle pulse, current move finished; cmd  out  16  muxed command; cmd_rdy  out  1  muxed valid; usurp  out  1  tour owns the command path; resp  out  8  response byte; err  out  1  sticky illegal-move flag.

Function
REQ-008 Move encoding (bit -> dx,dy): 0:+1,+2  1:-1,+2  2:-2,+1  3:-2,-1  4:-1,-2  5:+1,-2  6:+2,-1  7:+2,+1.
REQ-009 Leg command: vertical leg {4'b0010, heading, |dy|}, heading 8'h00 for dy>0 and 8'h7F for dy<0; horizontal leg {4'b0010, heading, |dx|}, heading 8'hBF for dx>0 and 8'h3F for dx<0.
REQ-010 The second leg of each move SHALL use opcode 4'b0011 (move with fanfare) in place of 4'b0010; HORIZ_FIRST selects which leg is second.
REQ-011 States: IDLE, LEG1, WAIT1, LEG2, WAIT2.
REQ-012 IDLE -> LEG1 on start_tour: mv_indx cleared to 0 and usurp set in the same edge.
REQ-013 LEGn: cmd_rdy=1; on clr_cmd_rdy -> WAITn.
REQ-014 WAITn: cmd_rdy=0; on send_resp, WAIT1 -> LEG2.
REQ-015 WAIT2 on send_resp with mv_indx<NUM_MOVES-1: mv_indx increments and the state returns to LEG1.
REQ-016 WAIT2 on send_resp with mv_indx==NUM_MOVES-1 -> IDLE, usurp=0; mv_indx holds its value, no wrap.
REQ-017 usurp=1 in all states other than IDLE.
REQ-018 usurp=0: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
REQ-019 usurp=1: cmd=leg command, clr_cmd_rdy_UART=0, resp=8'h5A; UART commands are ignored, not queued.
REQ-020 resp SHALL be 8'hA5 in the cycle after the final send_resp of a tour.
REQ-021 Illegal move (move not exactly one-hot) sampled on entry to LEG1: set err, go to IDLE, usurp=0, resp=8'hEE until the next start_tour; no command is issued.
REQ-022 err SHALL be cleared only by the next start_tour or by reset.
REQ-023 start_tour outside IDLE SHALL be ignored.
REQ-024 clr_cmd_rdy in WAITn and send_resp in LEGn SHALL be ignored.
REQ-025 clr_cmd_rdy and send_resp in the same cycle: only the event legal for the current state takes effect.
REQ-026 Latency: start_tour -> cmd_rdy=1 with a valid cmd in 1 clk; send_resp -> next leg's cmd_rdy in 1 clk.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, mv_indx=0, usurp=0, err=0, and the registered leg command to 16'h0000.
REQ-028 After rst_n low, outputs SHALL follow the UART path per REQ-018, mid-tour included; the interrupted tour does not resume.

Verification
REQ-029 Reset, then cmd_UART=16'h4022, cmd_rdy_UART=1 -> cmd=16'h4022, cmd_rdy=1, usurp=0, resp=8'hA5.
REQ-030 HORIZ_FIRST=0, start_tour, move=8'h01 -> cmd=16'h2002; after clr_cmd_rdy and send_resp -> cmd=16'h3BF1, resp=8'h5A.
REQ-031 HORIZ_FIRST=1, move=8'h08 -> cmd=16'h23F2, then 16'h37F1.
REQ-032 NUM_MOVES=4: drive 4 full moves -> mv_indx steps 0..3; after the final send_resp usurp=0 and resp=8'hA5 in the next cycle.
REQ-033 move=8'h03 at index 2 -> err=1, resp=8'hEE, usurp=0, no cmd_rdy pulse; next start_tour clears err.
REQ-034 rst_n low during WAIT2 at index 5 -> next cycle IDLE, mv_indx=0, cmd follows cmd_UART.

Source files
------------

// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: turns each one-hot knight move into two
// leg commands and owns the command path (usurp) while a tour is running.
module tour_cmd_seq #(
  parameter int NUM_MOVES   = 24,
  parameter int IDX_W       = $clog2(NUM_MOVES),
  parameter bit HORIZ_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  input  logic             clr_cmd_rdy,
  output logic             clr_cmd_rdy_UART,
  input  logic             send_resp,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  output logic             usurp,
  output logic [7:0]       resp,
  output logic             err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEG1  = 3'd1,
    WAIT1 = 3'd2,
    LEG2  = 3'd3,
    WAIT2 = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);
  localparam logic [3:0]       OP_MOVE  = 4'b0010;
  localparam logic [3:0]       OP_FANF  = 4'b0011;

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_mv_indx;
  logic             r_err;
  logic [7:0]       r_move;
  logic [15:0]      r_leg_cmd;

  logic w_move_ok;
  logic w_load_first;
  logic w_load_second;
  logic w_set_err;
  logic w_clr_err;
  logic w_idx_clr;
  logic w_idx_inc;
  logic w_usurp;

  // Leg command for one axis of a move: {opcode, heading, |delta|}.
  function automatic logic [15:0] leg_cmd(input logic [7:0] mv,
                                          input logic       horiz,
                                          input logic [3:0] op);
    logic dx_neg;
    logic dx_two;
    logic dy_neg;
    logic dy_two;
    dx_neg = mv[1] | mv[2] | mv[3] | mv[4];
    dx_two = mv[2] | mv[3] | mv[6] | mv[7];
    dy_neg = mv[3] | mv[4] | mv[5] | mv[6];
    dy_two = mv[0] | mv[1] | mv[4] | mv[5];
    if (horiz)
      leg_cmd = {op, (dx_neg ? 8'h3F : 8'hBF), (dx_two ? 4'd2 : 4'd1)};
    else
      leg_cmd = {op, (dy_neg ? 8'h7F : 8'h00), (dy_two ? 4'd2 : 4'd1)};
  endfunction

  assign w_move_ok = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);

  // Handshake: a leg is offered with cmd_rdy=1 in LEGn and is retired by
  // clr_cmd_rdy; the move is finished by send_resp in WAITn. Events outside
  // their own state are dropped, so a coincident clr/send_resp only acts on
  // the one matching the current state. The move input is sampled on the edge
  // that enters LEG1 and must already describe the move about to be executed.
  always_comb begin
    w_next_state  = r_state;
    w_load_first  = 1'b0;
    w_load_second = 1'b0;
    w_set_err     = 1'b0;
    w_clr_err     = 1'b0;
    w_idx_clr     = 1'b0;
    w_idx_inc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_tour) begin
          w_clr_err = 1'b1;
          w_idx_clr = 1'b1;
          if (w_move_ok) begin
            w_next_state = LEG1;
            w_load_first = 1'b1;
          end else begin
            w_set_err = 1'b1;
          end
        end
      end
      LEG1:  if (clr_cmd_rdy) w_next_state = WAIT1;
      WAIT1: begin
        if (send_resp) begin
          w_next_state  = LEG2;
          w_load_second = 1'b1;
        end
      end
      LEG2:  if (clr_cmd_rdy) w_next_state = WAIT2;
      WAIT2: begin
        if (send_resp) begin
          if (r_mv_indx == LAST_IDX) begin
            w_next_state = IDLE;
          end else begin
            w_idx_inc = 1'b1;
            if (w_move_ok) begin
              w_next_state = LEG1;
              w_load_first = 1'b1;
            end else begin
              w_next_state = IDLE;
              w_set_err    = 1'b1;
            end
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mv_indx <= '0;
      r_err     <= 1'b0;
      r_move    <= 8'h00;
      r_leg_cmd <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      if (w_idx_clr)
        r_mv_indx <= '0;
      else if (w_idx_inc)
        r_mv_indx <= r_mv_indx + 1'b1;
      if (w_set_err)
        r_err <= 1'b1;
      else if (w_clr_err)
        r_err <= 1'b0;
      if (w_load_first) begin
        r_move    <= move;
        r_leg_cmd <= leg_cmd(move, HORIZ_FIRST, OP_MOVE);
      end else if (w_load_second) begin
        r_leg_cmd <= leg_cmd(r_move, !HORIZ_FIRST, OP_FANF);
      end
    end
  end

  assign w_usurp = (r_state != IDLE);

  always_comb begin
    usurp            = w_usurp;
    mv_indx          = r_mv_indx;
    err              = r_err;
    dbg_state        = r_state;
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = r_err ? 8'hEE : 8'hA5;
    if (w_usurp) begin
      cmd              = r_leg_cmd;
      cmd_rdy          = (r_state == LEG1) || (r_state == LEG2);
      clr_cmd_rdy_UART = 1'b0;
      resp             = 8'h5A;
    end
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq: dut_a (24 moves, vertical first) and
// dut_b (4 moves, horizontal first) share one stimulus stream.
module tb_tour_cmd_seq;

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;

  logic [4:0]  mv_indx_a;
  logic        clr_uart_a;
  logic [15:0] cmd_a;
  logic        cmd_rdy_a;
  logic        usurp_a;
  logic [7:0]  resp_a;
  logic        err_a;
  logic [2:0]  dbg_a;

  logic [1:0]  mv_indx_b;
  logic        clr_uart_b;
  logic [15:0] cmd_b;
  logic        cmd_rdy_b;
  logic        usurp_b;
  logic [7:0]  resp_b;
  logic        err_b;
  logic [2:0]  dbg_b;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  tour_cmd_seq #(.NUM_MOVES(24), .HORIZ_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .mv_indx(mv_indx_a), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy(clr_cmd_rdy), .clr_cmd_rdy_UART(clr_uart_a),
    .send_resp(send_resp), .cmd(cmd_a), .cmd_rdy(cmd_rdy_a), .usurp(usurp_a),
    .resp(resp_a), .err(err_a), .dbg_state(dbg_a)
  );

  tour_cmd_seq #(.NUM_MOVES(4), .HORIZ_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .mv_indx(mv_indx_b), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy(clr_cmd_rdy), .clr_cmd_rdy_UART(clr_uart_b),
    .send_resp(send_resp), .cmd(cmd_b), .cmd_rdy(cmd_rdy_b), .usurp(usurp_b),
    .resp(resp_b), .err(err_b), .dbg_state(dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_resp();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    move         = 8'h00;
    cmd_UART     = 16'h0000;
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    tick();
    tick();
    check("rst_usurp", usurp_a, 0);
    check("rst_mv_indx", mv_indx_a, 0);
    check("rst_err", err_a, 0);
    check("rst_state", dbg_a, 0);
    rst_n = 1'b1;
    tick();

    // UART path while idle
    cmd_UART     = 16'h4022;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy  = 1'b1;
    #1;
    check("uart_cmd", cmd_a, 16'h4022);
    check("uart_cmd_rdy", cmd_rdy_a, 1);
    check("uart_usurp", usurp_a, 0);
    check("uart_resp", resp_a, 8'hA5);
    check("uart_clr_pass", clr_uart_a, 1);
    tick();
    clr_cmd_rdy = 1'b0;

    // first move 8'h01, both leg orders
    move = 8'h01;
    pulse_start();
    check("m01_leg1_a", cmd_a, 16'h2002);
    check("m01_leg1_b", cmd_b, 16'h2BF1);
    check("m01_cmd_rdy", cmd_rdy_a, 1);
    check("m01_usurp", usurp_a, 1);
    check("m01_resp", resp_a, 8'h5A);
    check("m01_idx", mv_indx_a, 0);
    send_resp = 1'b1;  // ignored in LEG1
    tick();
    send_resp = 1'b0;
    check("leg1_ignore_resp", cmd_rdy_a, 1);
    clr_cmd_rdy = 1'b1;
    #1;
    check("usurp_clr_block", clr_uart_a, 0);
    tick();
    clr_cmd_rdy = 1'b0;
    check("wait1_cmd_rdy", cmd_rdy_a, 0);
    pulse_clr();  // ignored in WAIT1
    check("wait1_ignore_clr", dbg_a, 2);
    pulse_resp();
    check("m01_leg2_a", cmd_a, 16'h3BF1);
    check("m01_leg2_b", cmd_b, 16'h3002);
    check("m01_leg2_resp", resp_a, 8'h5A);
    check("m01_leg2_rdy", cmd_rdy_a, 1);
    clr_cmd_rdy = 1'b1;  // coincident events in LEG2: only clr acts
    send_resp   = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    check("both_evt_state", dbg_a, 4);
    move = 8'h08;
    pulse_resp();
    check("idx1_a", mv_indx_a, 1);
    check("m08_leg1_a", cmd_a, 16'h27F1);
    pulse_start();  // ignored outside IDLE
    check("start_ignored_idx", mv_indx_a, 1);
    check("start_ignored_state", dbg_a, 1);
    do_reset();
    cmd_rdy_UART = 1'b0;

    // full 4-move tour on dut_b, move 8'h08 every step
    move = 8'h08;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(16'h23F2);
      exp_q.push_back(16'h37F1);
    end
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b_idx%0d", k), mv_indx_b, k);
      check($sformatf("b_leg1_%0d", k), cmd_b, exp_q.pop_front());
      pulse_clr();
      pulse_resp();
      check($sformatf("b_leg2_%0d", k), cmd_b, exp_q.pop_front());
      pulse_clr();
      pulse_resp();
    end
    check("b_end_usurp", usurp_b, 0);
    check("b_end_resp", resp_b, 8'hA5);
    check("b_end_idx_hold", mv_indx_b, 3);
    check("b_end_rdy", cmd_rdy_b, 0);
    check("a_still_running", usurp_a, 1);
    do_reset();

    // illegal move 8'h03 at index 2
    move = 8'h01;
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      pulse_clr();
      pulse_resp();
      pulse_clr();
      if (k == 1) move = 8'h03;
      pulse_resp();
    end
    check("ill_err", err_a, 1);
    check("ill_resp", resp_a, 8'hEE);
    check("ill_usurp", usurp_a, 0);
    check("ill_idx", mv_indx_a, 2);
    check("ill_rdy", cmd_rdy_a, 0);
    tick();
    check("ill_rdy_later", cmd_rdy_a, 0);
    check("ill_err_sticky", err_a, 1);
    move = 8'h00;
    pulse_start();  // zero move is also illegal
    check("zero_err", err_a, 1);
    check("zero_state", dbg_a, 0);
    move = 8'h01;
    pulse_start();
    check("restart_err_clr", err_a, 0);
    check("restart_cmd", cmd_a, 16'h2002);
    check("restart_idx", mv_indx_a, 0);
    do_reset();

    // reset during WAIT2 at index 5
    cmd_UART = 16'h1234;
    move     = 8'h01;
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      pulse_clr();
      pulse_resp();
      pulse_clr();
      if (k < 5) pulse_resp();
    end
    check("w2_idx5", mv_indx_a, 5);
    check("w2_state", dbg_a, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_usurp", usurp_a, 0);
    check("async_idx", mv_indx_a, 0);
    check("async_cmd", cmd_a, 16'h1234);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_rst_state", dbg_a, 0);
    check("after_rst_cmd", cmd_a, 16'h1234);
    check("after_rst_resp", resp_a, 8'hA5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
